// File: rtl/ofs_plat_prim_rob_alloc_arb_pkg.sv
`default_nettype none
// ============================================================================
// ofs_plat_prim_rob_alloc_arb_pkg : shared types and rotating-priority helper
// Revision 1.0
// ============================================================================
package ofs_plat_prim_rob_alloc_arb_pkg;

   localparam int C_N_REQ       = 4;
   localparam int C_N_ENTRIES   = 32;
   localparam int C_MAX_ALLOC   = 4;
   localparam int C_PORT_W      = $clog2(C_N_REQ);
   localparam int C_CNT_W       = $clog2(C_MAX_ALLOC) + 1;
   localparam int C_IDX_W       = $clog2(C_N_ENTRIES);
   localparam int C_MAX_REQ     = 32;
   localparam int C_MAX_REQ_W   = 5;

   typedef logic [C_PORT_W-1:0] t_port;
   typedef logic [C_CNT_W-1:0]  t_cnt;
   typedef logic [C_IDX_W-1:0]  t_idx;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } t_state;

   // First set bit of vec[n-1:0] at or above ptr, wrapping; 0 when none set.
   function automatic int unsigned rr_first(input logic [C_MAX_REQ-1:0] vec,
                                            input int unsigned ptr,
                                            input int unsigned n);
      int unsigned idx;
      int unsigned first;
      logic        found;
      first = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < C_MAX_REQ; i++) begin
         if (i < n) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && vec[idx[C_MAX_REQ_W-1:0]]) begin
               found = 1'b1;
               first = idx;
            end
         end
      end
      return first;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_plat_prim_rob_alloc_arb_credit.sv
`default_nettype none
// ============================================================================
// ofs_plat_prim_rob_alloc_credit : per-port outstanding-entry credit counter
// Revision 1.0
// ============================================================================
module ofs_plat_prim_rob_alloc_credit
   import ofs_plat_prim_rob_alloc_arb_pkg::*;
#(
   parameter int MAX_ALLOC_PER_CYCLE = 4,
   parameter int MAX_OUTSTANDING     = 16,
   parameter int CNT_W               = 3,
   parameter int OUT_W               = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid_i,
   input  logic [CNT_W-1:0] req_cnt_i,
   input  logic             grant_i,
   input  logic             rel_i,
   input  logic [CNT_W-1:0] rel_cnt_i,
   output logic             eligible_o
);

   localparam int SUM_W = OUT_W + CNT_W;

   logic [OUT_W-1:0] out_q;
   logic [OUT_W-1:0] out_d;
   logic             w_cnt_legal;
   logic [SUM_W-1:0] w_req_sum;
   logic [SUM_W-1:0] w_add;
   logic [SUM_W-1:0] w_sub;
   logic [SUM_W-1:0] w_net;

   // Wide intermediate so an underflow/overflow shows up as an out-of-range value.
   always_comb begin
      w_cnt_legal = (req_cnt_i != '0) && (32'(req_cnt_i) <= MAX_ALLOC_PER_CYCLE);
      w_req_sum   = SUM_W'(out_q) + SUM_W'(req_cnt_i);
      eligible_o  = req_valid_i && w_cnt_legal && (32'(w_req_sum) <= MAX_OUTSTANDING);
      w_add       = grant_i ? SUM_W'(req_cnt_i) : '0;
      w_sub       = rel_i   ? SUM_W'(rel_cnt_i) : '0;
      w_net       = SUM_W'(out_q) + w_add - w_sub;
      out_d       = w_net[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_q <= '0;
      else          out_q <= out_d;
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset_n) begin
         assert (32'(w_net) <= MAX_OUTSTANDING)
            else $fatal(1, "rob_alloc_credit: outstanding release underflow");
         if (req_valid_i)
            assert (w_cnt_legal)
               else $fatal(1, "rob_alloc_credit: illegal req_cnt with req_valid");
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/ofs_plat_prim_rob_alloc_arb.sv
`default_nettype none
// ============================================================================
// ofs_plat_prim_rob_alloc_arb : round-robin, credit-limited ROB allocation arbiter
// Revision 1.0
// ============================================================================
module ofs_plat_prim_rob_alloc_arb
   import ofs_plat_prim_rob_alloc_arb_pkg::*;
#(
   parameter  int N_REQ               = 4,
   parameter  int N_ENTRIES           = 32,
   parameter  int MAX_ALLOC_PER_CYCLE = 4,
   parameter  int N_REQ_META_BITS     = 8,
   parameter  int MAX_OUTSTANDING     = 16,
   localparam int IDX_W               = $clog2(N_ENTRIES),
   localparam int CNT_W               = $clog2(MAX_ALLOC_PER_CYCLE) + 1,
   localparam int OUT_W               = $clog2(MAX_OUTSTANDING + 1),
   localparam int PORT_W              = $clog2(N_REQ)
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [N_REQ-1:0]                  req_valid_i,
   input  logic [N_REQ*CNT_W-1:0]            req_cnt_i,
   input  logic [N_REQ*N_REQ_META_BITS-1:0]  req_meta_i,
   output logic [N_REQ-1:0]                  req_ready_o,
   output logic [IDX_W-1:0]                  grant_idx_o,
   output logic                              rob_alloc_en_o,
   output logic [CNT_W-1:0]                  rob_allocCnt_o,
   output logic [PORT_W+N_REQ_META_BITS-1:0] rob_allocMeta_o,
   input  logic                              rob_notFull_i,
   input  logic [IDX_W:0]                    rob_inSpaceAvail_i,
   input  logic [IDX_W-1:0]                  rob_allocIdx_i,
   input  logic                              rel_en_i,
   input  logic [PORT_W-1:0]                 rel_port_i,
   input  logic [CNT_W-1:0]                  rel_cnt_i
);

   t_state                     state_q, state_d;
   logic [PORT_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [PORT_W-1:0]          lock_port_q, lock_port_d;

   logic [N_REQ-1:0]           w_elig;
   logic [C_MAX_REQ-1:0]       w_elig_ext;
   logic [N_REQ-1:0]           w_port_grant;
   logic [N_REQ-1:0]           w_port_rel;
   logic [CNT_W-1:0]           w_cnt  [N_REQ];
   logic [N_REQ_META_BITS-1:0] w_meta [N_REQ];
   int unsigned                w_first;
   logic [PORT_W-1:0]          w_cand;
   logic [CNT_W-1:0]           w_cand_cnt;
   logic                       w_any_elig;
   logic                       w_fit;
   logic                       w_grant;

   for (genvar p = 0; p < N_REQ; p++) begin : g_port
      assign w_cnt[p]        = req_cnt_i[p*CNT_W +: CNT_W];
      assign w_meta[p]       = req_meta_i[p*N_REQ_META_BITS +: N_REQ_META_BITS];
      assign w_port_grant[p] = w_grant && (w_cand == PORT_W'(p));
      assign w_port_rel[p]   = rel_en_i && (rel_port_i == PORT_W'(p));

      ofs_plat_prim_rob_alloc_credit #(
         .MAX_ALLOC_PER_CYCLE (MAX_ALLOC_PER_CYCLE),
         .MAX_OUTSTANDING     (MAX_OUTSTANDING),
         .CNT_W               (CNT_W),
         .OUT_W               (OUT_W)
      ) u_credit (
         .clk         (clk),
         .reset_n     (reset_n),
         .req_valid_i (req_valid_i[p]),
         .req_cnt_i   (w_cnt[p]),
         .grant_i     (w_port_grant[p]),
         .rel_i       (w_port_rel[p]),
         .rel_cnt_i   (rel_cnt_i),
         .eligible_o  (w_elig[p])
      );
   end

   // In LOCKED only the locked port competes; credit-blocked ports never lock.
   always_comb begin
      w_elig_ext             = '0;
      w_elig_ext[N_REQ-1:0]  = w_elig;
      w_first                = rr_first(w_elig_ext, 32'(rr_ptr_q), N_REQ);
      w_any_elig             = |w_elig;
      w_cand                 = (state_q == LOCKED) ? lock_port_q : PORT_W'(w_first);
      w_cand_cnt             = w_cnt[w_cand];
      w_fit                  = rob_notFull_i &&
                               (32'(rob_inSpaceAvail_i) >= 32'(w_cand_cnt));
      w_grant                = reset_n && w_elig[w_cand] && w_fit &&
                               ((state_q == LOCKED) || w_any_elig);

      state_d     = state_q;
      lock_port_d = lock_port_q;
      rr_ptr_d    = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (w_any_elig && !w_fit) begin
               state_d     = LOCKED;
               lock_port_d = w_cand;
            end
         end
         LOCKED: begin
            if (!req_valid_i[lock_port_q] || w_grant) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (w_grant)
         rr_ptr_d = (w_cand == PORT_W'(N_REQ - 1)) ? '0 : w_cand + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         lock_port_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_port_q <= lock_port_d;
      end
   end

   assign req_ready_o     = w_port_grant;
   assign rob_alloc_en_o  = w_grant;
   assign rob_allocCnt_o  = w_grant ? w_cand_cnt : '0;
   assign rob_allocMeta_o = w_grant ? {w_cand, w_meta[w_cand]} : '0;
   assign grant_idx_o     = rob_allocIdx_i;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset_n && (state_q == LOCKED))
         assert (req_valid_i[lock_port_q])
            else $fatal(1, "rob_alloc_arb: req_valid dropped on locked port");
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_prim_rob_alloc_arb.sv
`default_nettype none
// ============================================================================
// tb_ofs_plat_prim_rob_alloc_arb : directed scoreboard bench for the ROB alloc arbiter
// Revision 1.0
// ============================================================================
module tb_ofs_plat_prim_rob_alloc_arb;
   import ofs_plat_prim_rob_alloc_arb_pkg::*;

   localparam logic [7:0] META_TBL [4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [2:0]  cnt [4];
   logic [11:0] req_cnt;
   logic [31:0] req_meta;
   logic [3:0]  req_ready;
   t_idx        grant_idx;
   logic        rob_alloc_en;
   logic [2:0]  rob_allocCnt;
   logic [9:0]  rob_allocMeta;
   logic        rob_notFull;
   logic [5:0]  rob_space;
   t_idx        rob_allocIdx;
   logic        rel_en;
   logic [1:0]  rel_port;
   logic [2:0]  rel_cnt;

   typedef struct {
      int         cyc;
      int         port;
      logic [2:0] cnt;
      logic [9:0] meta;
      t_idx       idx;
   } exp_t;

   exp_t q[$];
   int   cyc;
   int   n_cmp;
   int   n_bad;
   t_idx idx_m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_cnt = '0;
      for (int p = 0; p < 4; p++) req_cnt[p*3 +: 3] = cnt[p];
   end
   assign req_meta = {META_TBL[3], META_TBL[2], META_TBL[1], META_TBL[0]};

   ofs_plat_prim_rob_alloc_arb dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .req_valid_i        (req_valid),
      .req_cnt_i          (req_cnt),
      .req_meta_i         (req_meta),
      .req_ready_o        (req_ready),
      .grant_idx_o        (grant_idx),
      .rob_alloc_en_o     (rob_alloc_en),
      .rob_allocCnt_o     (rob_allocCnt),
      .rob_allocMeta_o    (rob_allocMeta),
      .rob_notFull_i      (rob_notFull),
      .rob_inSpaceAvail_i (rob_space),
      .rob_allocIdx_i     (rob_allocIdx),
      .rel_en_i           (rel_en),
      .rel_port_i         (rel_port),
      .rel_cnt_i          (rel_cnt)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endfunction

   // Drive one cycle of stimulus; ep >= 0 names the port expected to win this cycle.
   task automatic step(input logic [3:0] v, input logic re, input int rp, input int rc, input int ep);
      exp_t e;
      req_valid    = v;
      rel_en       = re;
      rel_port     = 2'(rp);
      rel_cnt      = 3'(rc);
      rob_allocIdx = idx_m;
      if (ep >= 0) begin
         e.cyc  = cyc;
         e.port = ep;
         e.cnt  = cnt[ep];
         e.meta = {2'(ep), META_TBL[ep]};
         e.idx  = idx_m;
         q.push_back(e);
         idx_m  = idx_m + 5'(cnt[ep]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_cnt(input int c0, input int c1, input int c2, input int c3);
      cnt[0] = 3'(c0); cnt[1] = 3'(c1); cnt[2] = 3'(c2); cnt[3] = 3'(c3);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         chk("grant_missing", 32'(cyc), 32'(q[0].cyc));
         void'(q.pop_front());
      end
      if (rob_alloc_en) begin
         if (q.size() == 0) begin
            chk("spurious_grant", 32'(rob_alloc_en), 32'd0);
         end else begin
            e = q.pop_front();
            chk("grant_cycle", 32'(cyc), 32'(e.cyc));
            chk("req_ready", 32'(req_ready), 32'(1) << e.port);
            chk("rob_allocCnt", 32'(rob_allocCnt), 32'(e.cnt));
            chk("rob_allocMeta", 32'(rob_allocMeta), 32'(e.meta));
            chk("grant_idx", 32'(grant_idx), 32'(e.idx));
         end
      end else begin
         chk("idle_ready", 32'(req_ready), 32'd0);
         chk("idle_cnt_meta", {19'd0, rob_allocCnt, rob_allocMeta}, 32'd0);
      end
   end

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_alloc_en"}, 32'(rob_alloc_en), 32'd0);
      chk({tag, "_allocCnt"}, 32'(rob_allocCnt), 32'd0);
      chk({tag, "_allocMeta"}, 32'(rob_allocMeta), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n      = 1'b0;
      req_valid    = 4'hF;
      set_cnt(1, 1, 1, 1);
      rob_notFull  = 1'b1;
      rob_space    = 6'd32;
      rob_allocIdx = '0;
      rel_en       = 1'b0;
      rel_port     = '0;
      rel_cnt      = '0;
      idx_m        = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      req_valid = 4'h0;
      reset_n   = 1'b1;

      // Round robin with unit requests.
      for (int k = 0; k < 5; k++) step(4'hF, 1'b0, 0, 0, k % 4);
      step(4'h0, 1'b1, 0, 2, -1);
      for (int p = 1; p < 4; p++) step(4'h0, 1'b1, p, 1, -1);

      // Large request on port 1 locks out smaller ones until space appears.
      set_cnt(1, 4, 1, 1);
      rob_space = 6'd2;
      repeat (3) step(4'b1110, 1'b0, 0, 0, -1);
      rob_space = 6'd4;
      step(4'b1110, 1'b0, 0, 0, 1);
      step(4'b1100, 1'b0, 0, 0, 2);
      step(4'b1100, 1'b0, 0, 0, 3);
      rob_space = 6'd32;
      step(4'h0, 1'b1, 1, 4, -1);
      step(4'h0, 1'b1, 2, 1, -1);
      step(4'h0, 1'b1, 3, 1, -1);

      // Credit limit on port 0: 14 outstanding blocks a request of 4.
      set_cnt(4, 1, 1, 1);
      repeat (3) step(4'b0001, 1'b0, 0, 0, 0);
      cnt[0] = 3'd2;
      step(4'b0001, 1'b0, 0, 0, 0);
      step(4'b1000, 1'b0, 0, 0, 3);
      cnt[0] = 3'd4;
      step(4'b0101, 1'b0, 0, 0, 2);
      step(4'b0001, 1'b1, 0, 2, -1);
      step(4'b0001, 1'b0, 0, 0, 0);
      cnt[0] = 3'd1;
      step(4'b0001, 1'b0, 0, 0, -1);
      repeat (4) step(4'h0, 1'b1, 0, 4, -1);
      step(4'h0, 1'b1, 3, 1, -1);
      step(4'h0, 1'b1, 2, 1, -1);

      // Same-cycle grant(3)/release(2) on port 2 nets +1; probe it at the limit.
      set_cnt(1, 1, 3, 1);
      step(4'b0100, 1'b0, 0, 0, 2);
      step(4'b0100, 1'b1, 2, 2, 2);
      cnt[2] = 3'd4;
      repeat (3) step(4'b0100, 1'b0, 0, 0, 2);
      cnt[2] = 3'd1;
      step(4'b0100, 1'b0, 0, 0, -1);
      repeat (4) step(4'h0, 1'b1, 2, 4, -1);

      // Reset asserted while locked with 5 entries outstanding.
      set_cnt(1, 4, 1, 1);
      step(4'b1010, 1'b0, 0, 0, 3);
      step(4'b1010, 1'b0, 0, 0, 1);
      rob_space = 6'd2;
      step(4'b0010, 1'b0, 0, 0, -1);
      rob_space = 6'd4;
      reset_n   = 1'b0;
      #1;
      chk_outputs_zero("lock_reset");
      @(posedge clk);
      #1;
      req_valid = 4'h0;
      rob_space = 6'd32;
      reset_n   = 1'b1;
      set_cnt(1, 1, 1, 1);
      step(4'hF, 1'b0, 0, 0, 0);
      step(4'hF, 1'b0, 0, 0, 1);
      cnt[3] = 3'd4;
      repeat (4) step(4'b1000, 1'b0, 0, 0, 3);
      cnt[3] = 3'd1;
      step(4'b1000, 1'b0, 0, 0, -1);
      step(4'h0, 1'b1, 0, 1, -1);
      step(4'h0, 1'b1, 1, 1, -1);
      repeat (4) step(4'h0, 1'b1, 3, 4, -1);

      // ROB not full gating, then granted in the cycle it clears.
      set_cnt(1, 1, 2, 1);
      rob_notFull = 1'b0;
      rob_space   = 6'd4;
      repeat (2) step(4'b0100, 1'b0, 0, 0, -1);
      rob_notFull = 1'b1;
      step(4'b0100, 1'b0, 0, 0, 2);
      rob_space = 6'd32;
      step(4'h0, 1'b1, 2, 2, -1);

      repeat (3) step(4'h0, 1'b0, 0, 0, -1);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
